// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller.
// Accepts the M-stage access, drives a req/ack data-memory port with aligned
// byte enables and lane-replicated store data, and returns the extended load
// result. stallM holds the pipeline while an access is outstanding.
module mem_access_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memreadM,
    input  logic            memwriteM,
    input  logic [XLEN-1:0] addrM,
    input  logic [XLEN-1:0] wdataM,
    input  logic [1:0]      swhbM,
    input  logic            lunsignedM,
    output logic            stallM,
    output logic [XLEN-1:0] rdataM,
    output logic            misalign_err,
    output logic            bus_err,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata
);

    // Counter just wide enough to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Registered copy of the access, held stable for the whole request.
    logic [XLEN-1:0] addr_reg;
    logic [3:0]      be_reg;
    logic            we_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [1:0]      offset_reg;
    logic            half_reg;
    logic            byte_reg;
    logic            unsigned_reg;
    logic [XLEN-1:0] rdata_reg;
    logic            timed_out_reg;
    logic [CW-1:0]   count_reg;

    // Size decode: 10 half, 11 byte, anything else is a word.
    logic is_half, is_byte, is_word;
    logic access, misaligned;
    assign is_half    = (swhbM == 2'b10);
    assign is_byte    = (swhbM == 2'b11);
    assign is_word    = ~is_half & ~is_byte;
    assign access     = memreadM | memwriteM;
    assign misaligned = (is_half & addrM[0]) | (is_word & (addrM[1:0] != 2'b00));

    // Per-lane byte enable and store data replication.
    logic [3:0]      be_dec;
    logic [XLEN-1:0] wdata_dec;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign be_dec[gi] = is_byte ? (addrM[1:0] == LANE) :
                                is_half ? (addrM[1] == LANE[1]) : 1'b1;
            assign wdata_dec[8*gi +: 8] = is_byte ? wdataM[7:0] :
                                          is_half ? wdataM[8*(gi%2) +: 8] :
                                                    wdataM[8*gi +: 8];
        end
    endgenerate

    // Timeout detection; TIMEOUT of zero disables it entirely.
    logic timeout_hit;
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign timeout_hit = (count_reg == CW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Lane extraction and sign/zero extension of the returned word.
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] load_ext;
    always_comb begin
        lane_b   = dmem_rdata[{offset_reg, 3'b000} +: 8];
        lane_h   = offset_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_ext = dmem_rdata;
        if (byte_reg) begin
            load_ext = {{(XLEN-8){~unsigned_reg & lane_b[7]}}, lane_b};
        end else if (half_reg) begin
            load_ext = {{(XLEN-16){~unsigned_reg & lane_h[15]}}, lane_h};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, stall and misalignment decode.
    always_comb begin
        state_next   = state_reg;
        stallM       = 1'b0;
        misalign_err = 1'b0;
        case (state_reg)
            IDLE: begin
                if (access && !reset) begin
                    if (misaligned) begin
                        misalign_err = 1'b1;
                    end else begin
                        stallM     = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                stallM = ~reset;
                if (dmem_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the access on entry to REQ, count wait cycles, latch the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg      <= '0;
            be_reg        <= '0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
            offset_reg    <= '0;
            half_reg      <= 1'b0;
            byte_reg      <= 1'b0;
            unsigned_reg  <= 1'b0;
            rdata_reg     <= '0;
            timed_out_reg <= 1'b0;
            count_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (access && !misaligned) begin
                        addr_reg      <= {addrM[XLEN-1:2], 2'b00};
                        be_reg        <= be_dec;
                        we_reg        <= memwriteM;
                        wdata_reg     <= memwriteM ? wdata_dec : '0;
                        offset_reg    <= addrM[1:0];
                        half_reg      <= is_half;
                        byte_reg      <= is_byte;
                        unsigned_reg  <= lunsignedM;
                        rdata_reg     <= '0;
                        timed_out_reg <= 1'b0;
                        count_reg     <= '0;
                    end
                end
                REQ: begin
                    count_reg <= count_reg + CW'(1);
                    if (dmem_ack) begin
                        rdata_reg <= we_reg ? '0 : load_ext;
                    end else if (timeout_hit) begin
                        rdata_reg     <= '0;
                        timed_out_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory port is only driven while a request is outstanding.
    assign dmem_req   = (state_reg == REQ);
    assign dmem_we    = dmem_req & we_reg;
    assign dmem_addr  = dmem_req ? addr_reg  : '0;
    assign dmem_be    = dmem_req ? be_reg    : 4'b0000;
    assign dmem_wdata = dmem_req ? wdata_reg : '0;

    // Result and bus error are presented only in the retire cycle.
    assign rdataM  = (state_reg == DONE) ? rdata_reg : '0;
    assign bus_err = (state_reg == DONE) & timed_out_reg;

endmodule
